// File: rtl/pc_unit_pkg.sv
// Shared types for the program counter: operation encoding, priority decode
// and the return-stack count width. Relative branches are enabled by PC_REL_BRANCH_EN.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_CONFLICT
  } op_e;

  // Priority: conflict > RET > CALL > LOAD > INC > hold.
  function automatic op_e decode_op(input logic inc, input logic load,
                                    input logic call, input logic ret);
    op_e op;
    if (call && ret) op = OP_CONFLICT;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (load)   op = OP_LOAD;
    else if (inc)    op = OP_INC;
    else             op = OP_HOLD;
    return op;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the sequencer (master) and pc_unit (slave).
// The rel signal exists only when PC_REL_BRANCH_EN is defined.
interface pc_unit_if #(parameter int WIDTH = 16);
  logic             inc;
  logic             load;
  logic             call;
  logic             ret;
  logic             clr_err;
`ifdef PC_REL_BRANCH_EN
  logic             rel;
`endif
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output inc, load, call, ret, clr_err, d,
`ifdef PC_REL_BRANCH_EN
    output rel,
`endif
    input  q, full, empty, err
  );

  modport slave (
    input  inc, load, call, ret, clr_err, d,
`ifdef PC_REL_BRANCH_EN
    input  rel,
`endif
    output q, full, empty, err
  );
endinterface

// File: rtl/pc_unit_ret_stack.sv
// LIFO of return addresses with an occupancy counter; the counter clears
// asynchronously, entry contents are left untouched on reset.
module pc_unit_ret_stack
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [AW-1:0]    top_idx;

  assign top_idx = AW'(cnt_q - CNT_ONE);
  assign top_o   = mem_q[top_idx];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push_i)     cnt_d = cnt_q + CNT_ONE;
    else if (pop_i) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Push is only issued when not full, so cnt_q always indexes a valid slot.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[AW'(cnt_q)] <= data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with return-address stack and sticky ERR flag.
// Define PC_REL_BRANCH_EN to make LOAD/CALL targets Q+D when rel is set.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] q_plus1;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] top;
  logic             full, empty;
  logic             push, pop, fault;
  op_e              op;

  assign q_plus1 = q_q + WIDTH'(1);
  assign op      = decode_op(bus.inc, bus.load, bus.call, bus.ret);

`ifdef PC_REL_BRANCH_EN
  assign target = bus.rel ? (q_q + bus.d) : bus.d;
`else
  assign target = bus.d;
`endif

  always_comb begin
    q_d   = q_q;
    push  = 1'b0;
    pop   = 1'b0;
    fault = 1'b0;
    unique case (op)
      OP_CONFLICT: fault = 1'b1;
      OP_RET: begin
        if (empty) fault = 1'b1;
        else begin
          pop = 1'b1;
          q_d = top;
        end
      end
      OP_CALL: begin
        if (full) fault = 1'b1;
        else begin
          push = 1'b1;
          q_d  = target;
        end
      end
      OP_LOAD: q_d = target;
      OP_INC:  q_d = q_plus1;
      default: q_d = q_q;
    endcase
    // A fault in the same cycle as clr_err keeps the flag set.
    err_d = fault ? 1'b1 : (bus.clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  pc_unit_ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (q_plus1),
    .top_o   (top),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.q     = q_q;
  assign bus.err   = err_q;
  assign bus.full  = full;
  assign bus.empty = empty;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: fixed vector table, hand sequences for
// stack depth and async reset, and randomized traffic against a queue model.
module tb_pc_unit;
  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(W)) bus ();

  pc_unit #(.WIDTH(W), .DEPTH(N), .RESET_VEC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_q;
  logic [W-1:0] m_stk[$];
  logic         m_err;

  typedef struct {
    logic [4:0]   ctl;   // {inc, load, call, ret, clr_err}
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic [2:0]   exp_f; // {full, empty, err}
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 16'h0000;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic inc, input logic ld, input logic cl,
                            input logic rt, input logic clr, input logic rel,
                            input logic [W-1:0] d);
    logic [W-1:0] tgt;
    logic         flt;
    tgt = rel ? m_q + d : d;
    flt = 1'b0;
    if (cl && rt) flt = 1'b1;
    else if (rt) begin
      if (m_stk.size() == 0) flt = 1'b1;
      else m_q = m_stk.pop_back();
    end else if (cl) begin
      if (m_stk.size() == N) flt = 1'b1;
      else begin
        m_stk.push_back(m_q + 16'h0001);
        m_q = tgt;
      end
    end else if (ld) m_q = tgt;
    else if (inc) m_q = m_q + 16'h0001;
    if (flt) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic do_cycle(input logic inc, input logic ld, input logic cl,
                          input logic rt, input logic clr, input logic rel,
                          input logic [W-1:0] d);
    bus.inc = inc; bus.load = ld; bus.call = cl; bus.ret = rt;
    bus.clr_err = clr; bus.d = d;
`ifdef PC_REL_BRANCH_EN
    bus.rel = rel;
`endif
    model_step(inc, ld, cl, rt, clr, rel, d);
    @(posedge clk);
    #1;
    bus.inc = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.clr_err = 1'b0;
`ifdef PC_REL_BRANCH_EN
    bus.rel = 1'b0;
`endif
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},     32'(bus.q),     32'(m_q));
    check({tag, ".full"},  32'(bus.full),  32'(m_stk.size() == N));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_stk.size() == 0));
    check({tag, ".err"},   32'(bus.err),   32'(m_err));
  endtask

  initial begin
    tbl[0]  = '{5'b01000, 16'hFFFE, 16'hFFFE, 3'b010};
    tbl[1]  = '{5'b10000, 16'h0000, 16'hFFFF, 3'b010};
    tbl[2]  = '{5'b10000, 16'h0000, 16'h0000, 3'b010};
    tbl[3]  = '{5'b10000, 16'h0000, 16'h0001, 3'b010};
    tbl[4]  = '{5'b01000, 16'h0010, 16'h0010, 3'b010};
    tbl[5]  = '{5'b00100, 16'h0200, 16'h0200, 3'b000};
    tbl[6]  = '{5'b00010, 16'h0000, 16'h0011, 3'b010};
    tbl[7]  = '{5'b00010, 16'h0000, 16'h0011, 3'b011};
    tbl[8]  = '{5'b00001, 16'h0000, 16'h0011, 3'b010};
    tbl[9]  = '{5'b00110, 16'h0500, 16'h0011, 3'b011};
    tbl[10] = '{5'b10001, 16'h0000, 16'h0012, 3'b010};
    tbl[11] = '{5'b11000, 16'h0777, 16'h0777, 3'b010};
    tbl[12] = '{5'b01100, 16'h0100, 16'h0100, 3'b000};
    tbl[13] = '{5'b00011, 16'h0000, 16'h0778, 3'b010};
    tbl[14] = '{5'b00011, 16'h0000, 16'h0778, 3'b011};
    tbl[15] = '{5'b00001, 16'h0000, 16'h0778, 3'b010};
    tbl[16] = '{5'b00000, 16'h1234, 16'h0778, 3'b010};
    tbl[17] = '{5'b01000, 16'hFFFF, 16'hFFFF, 3'b010};
    tbl[18] = '{5'b00100, 16'h0003, 16'h0003, 3'b000};
    tbl[19] = '{5'b00010, 16'h0000, 16'h0000, 3'b010};

    bus.inc = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.clr_err = 1'b0; bus.d = '0;
`ifdef PC_REL_BRANCH_EN
    bus.rel = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.q",     32'(bus.q),     32'h0000);
    check("reset.full",  32'(bus.full),  32'h0);
    check("reset.empty", 32'(bus.empty), 32'h1);
    check("reset.err",   32'(bus.err),   32'h0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      do_cycle(tbl[i].ctl[4], tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1],
               tbl[i].ctl[0], 1'b0, tbl[i].d);
      check($sformatf("vec%0d.q", i),    32'(bus.q), 32'(tbl[i].exp_q));
      check($sformatf("vec%0d.flags", i), 32'({bus.full, bus.empty, bus.err}),
            32'(tbl[i].exp_f));
    end

    // Fill the stack, overflow once, then unwind in LIFO order.
    for (int i = 0; i < N; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000 + 16'(i));
      check($sformatf("fill%0d.q", i), 32'(bus.q), 32'h1000 + i);
    end
    check("fill.full", 32'(bus.full), 32'h1);
    check("fill.err",  32'(bus.err),  32'h0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2000);
    check("ovf.q",    32'(bus.q),    32'h1007);
    check("ovf.err",  32'(bus.err),  32'h1);
    check("ovf.full", 32'(bus.full), 32'h1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("ovf.clr", 32'(bus.err), 32'h0);
    for (int i = 0; i < N; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      check($sformatf("unwind%0d.q", i), 32'(bus.q),
            (i == N - 1) ? 32'h0001 : 32'h1007 - i);
    end
    check("unwind.empty", 32'(bus.empty), 32'h1);
    check("unwind.err",   32'(bus.err),   32'h0);

    // Asynchronous reset mid-run: nonempty stack, ERR set, Q=0x0123.
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0999);
    check("pre_rst.q",   32'(bus.q),   32'h0123);
    check("pre_rst.err", 32'(bus.err), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst.q",     32'(bus.q),     32'h0000);
    check("async_rst.empty", 32'(bus.empty), 32'h1);
    check("async_rst.full",  32'(bus.full),  32'h0);
    check("async_rst.err",   32'(bus.err),   32'h0);
    model_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rd;
      rd = 16'($urandom);
      do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0,
`ifdef PC_REL_BRANCH_EN
               $urandom_range(0, 2) == 0,
`else
               1'b0,
`endif
               rd);
      check_model($sformatf("rand%0d", i));
    end

`ifdef PC_REL_BRANCH_EN
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
    check("rel.setup", 32'(bus.q), 32'h0100);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF0);
    check("rel.load_back", 32'(bus.q), 32'h00F0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040);
    check("rel.load_abs", 32'(bus.q), 32'h0040);
    check_model("rel.model");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
